// File: rtl/lbfr_rd_scheduler.sv
// Round-robin read scheduler: grants one ready line buffer, pulses header start, then drives its read enable until lastwd or timeout.
// Latency: ready sampled in IDLE at edge N -> hdr_start_o in cycle N+1 -> rd_en_o from cycle N+2; all outputs registered.
// Backpressure: enable_i/tx_busy_i only gate new grants in IDLE; a granted packet always runs to lastwd or timeout, then a fixed gap.
module lbfr_rd_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       tx_clk_i,
  input  logic                       reset_tx_n_i,
  input  logic                       enable_i,
  input  logic                       tx_busy_i,
  input  logic [NUM_CH-1:0]          ch_ready_i,
  input  logic [16*NUM_CH-1:0]       ch_wc_i,
  input  logic [NUM_CH-1:0]          ch_lastwd_i,
  output logic [NUM_CH-1:0]          rd_en_o,
  output logic [15:0]                wdcnt_o,
  output logic [$clog2(NUM_CH)-1:0]  grant_id_o,
  output logic                       hdr_start_o,
  output logic                       pkt_done_o,
  output logic                       timeout_o
);

  localparam int          IDW      = $clog2(NUM_CH);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_READ, ST_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [IDW-1:0]    r_last, w_last_nxt;
  logic [IDW-1:0]    r_grant, w_grant_nxt;
  logic [15:0]       r_wdcnt, w_wdcnt_nxt;
  logic [NUM_CH-1:0] r_rd_en, w_rd_en_nxt;
  logic              r_hdr, w_hdr_nxt;
  logic              r_done, w_done_nxt;
  logic              r_to, w_to_nxt;

  logic              w_pick_vld;
  logic [IDW-1:0]    w_pick_id;
  logic [IDW-1:0]    w_idx;
  logic [15:0]       w_pick_wc;
  logic [NUM_CH-1:0] w_grant_oh;

  // Round-robin search: walk from farthest to nearest after last grant so the nearest ready channel wins
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    w_idx      = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      w_idx = IDW'((int'(r_last) + i) % NUM_CH);
      if (ch_ready_i[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = w_idx;
      end
    end
  end

  // Word count of the candidate channel, latched only on grant
  always_comb begin
    w_pick_wc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_pick_id == IDW'(k)) w_pick_wc = ch_wc_i[16*k +: 16];
    end
  end

  // One-hot read enable for the held grant; the only pattern rd_en_o can take
  always_comb begin
    w_grant_oh          = '0;
    w_grant_oh[r_grant] = 1'b1;
  end

  // Packet sequencer: next state plus next values of every registered output
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_wdcnt_nxt = r_wdcnt;
    w_rd_en_nxt = '0;
    w_hdr_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_to_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && !tx_busy_i && w_pick_vld) begin
          w_grant_nxt = w_pick_id;
          w_last_nxt  = w_pick_id;
          w_wdcnt_nxt = w_pick_wc;
          w_hdr_nxt   = 1'b1;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        w_cnt_nxt = '0;
        if (r_wdcnt == 16'd0) begin
          // Empty line: header only, finish without touching the buffer
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_rd_en_nxt = w_grant_oh;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        // lastwd is checked first so it wins over a coincident timeout
        if (ch_lastwd_i[r_grant]) begin
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == TO_LAST) begin
          w_to_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else begin
          w_rd_en_nxt = w_grant_oh;
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything and points last grant at the top channel
  always_ff @(posedge tx_clk_i or negedge reset_tx_n_i) begin
    if (!reset_tx_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= IDW'(NUM_CH - 1);
      r_grant <= '0;
      r_wdcnt <= '0;
      r_rd_en <= '0;
      r_hdr   <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_wdcnt <= w_wdcnt_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_hdr   <= w_hdr_nxt;
      r_done  <= w_done_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign rd_en_o     = r_rd_en;
  assign wdcnt_o     = r_wdcnt;
  assign grant_id_o  = r_grant;
  assign hdr_start_o = r_hdr;
  assign pkt_done_o  = r_done;
  assign timeout_o   = r_to;

endmodule

// File: tb/tb_lbfr_rd_scheduler.sv
// Bench for lbfr_rd_scheduler: packet-level monitor plus round-robin/timing reference model.
// Latency: expectations are derived per packet (header, first read, read length, end pulse, gap).
// Backpressure: exercises tx_busy_i, enable_i drop, lastwd/timeout ends and asynchronous reset.
`timescale 1ns/1ps
module tb_lbfr_rd_scheduler;
  localparam int NUM_CH      = 4;
  localparam int GAP_CYCLES  = 8;
  localparam int TIMEOUT_CYC = 4096;

  logic                 tx_clk_i = 1'b0;
  logic                 reset_tx_n_i;
  logic                 enable_i;
  logic                 tx_busy_i;
  logic [NUM_CH-1:0]    ch_ready_i;
  logic [16*NUM_CH-1:0] ch_wc_i;
  logic [NUM_CH-1:0]    ch_lastwd_i;
  logic [NUM_CH-1:0]    rd_en_o;
  logic [15:0]          wdcnt_o;
  logic [1:0]           grant_id_o;
  logic                 hdr_start_o;
  logic                 pkt_done_o;
  logic                 timeout_o;

  lbfr_rd_scheduler #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .tx_clk_i(tx_clk_i), .reset_tx_n_i(reset_tx_n_i), .enable_i(enable_i), .tx_busy_i(tx_busy_i),
    .ch_ready_i(ch_ready_i), .ch_wc_i(ch_wc_i), .ch_lastwd_i(ch_lastwd_i), .rd_en_o(rd_en_o),
    .wdcnt_o(wdcnt_o), .grant_id_o(grant_id_o), .hdr_start_o(hdr_start_o),
    .pkt_done_o(pkt_done_o), .timeout_o(timeout_o)
  );

  always #5 tx_clk_i = ~tx_clk_i;

  // One observed packet; first_rd = 0 means no read cycle, kind 1 = done, 2 = timeout
  typedef struct packed {
    int ch; int wc; int hdr; int first_rd; int rd_len; int kind; int endc;
  } pkt_t;

  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  bit   open = 1'b0;
  pkt_t cur;
  pkt_t pkts[$];
  int   bad_rd = 0;
  int   bad_pulse = 0;
  int   lw_delay[NUM_CH];
  logic [15:0] wcs[NUM_CH];
  int   m_last;

  // Monitor: turns output activity into packet records and counts protocol violations
  initial begin
    forever begin
      @(negedge tx_clk_i);
      ncyc++;
      if (!reset_tx_n_i) begin
        open = 1'b0;
        continue;
      end
      if (hdr_start_o) begin
        if (rd_en_o != '0) bad_rd++;
        cur = '{ch: int'(grant_id_o), wc: int'(wdcnt_o), hdr: ncyc, first_rd: 0, rd_len: 0, kind: 0, endc: 0};
        open = 1'b1;
      end else if (rd_en_o != '0) begin
        if (!open || rd_en_o != (4'b0001 << grant_id_o)) bad_rd++;
        if (cur.first_rd == 0) cur.first_rd = ncyc;
        cur.rd_len++;
      end
      if (pkt_done_o || timeout_o) begin
        if (pkt_done_o && timeout_o) bad_pulse++;
        if (!open) bad_pulse++;
        else begin
          cur.kind = pkt_done_o ? 1 : 2;
          cur.endc = ncyc;
          pkts.push_back(cur);
          open = 1'b0;
        end
      end
    end
  end

  // Line-buffer model: granted channel flags lastwd on its lw_delay-th read cycle; others toggle randomly
  initial begin
    logic [NUM_CH-1:0] lw;
    int rd_cnt;
    rd_cnt = 0;
    ch_lastwd_i = '0;
    forever begin
      @(negedge tx_clk_i);
      lw = '0;
      for (int k = 0; k < NUM_CH; k++)
        if (k != int'(grant_id_o)) lw[k] = 1'($urandom_range(0, 1));
      if (rd_en_o[grant_id_o] === 1'b1) begin
        rd_cnt++;
        lw[grant_id_o] = (rd_cnt == lw_delay[grant_id_o]);
      end else begin
        rd_cnt = 0;
      end
      ch_lastwd_i = lw;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog sim time exceeded checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(negedge tx_clk_i);
    #1;
  endtask

  task automatic apply_wc();
    for (int k = 0; k < NUM_CH; k++) ch_wc_i[16*k +: 16] = wcs[k];
  endtask

  task automatic do_reset();
    reset_tx_n_i = 1'b0;
    repeat (2) tick();
    reset_tx_n_i = 1'b1;
    m_last = NUM_CH - 1;
    tick();
  endtask

  // Enables scheduling until n packets are recorded, then disables and waits out the gap
  task automatic run_pkts(input int n, input int budget, output int t0, output bit ok);
    pkts.delete();
    enable_i = 1'b1;
    t0 = ncyc;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (pkts.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    enable_i = 1'b0;
    for (int c = 0; c < 10000 && open; c++) tick();
    repeat (GAP_CYCLES + 4) tick();
  endtask

  function automatic int rr_pick(int last, logic [NUM_CH-1:0] rdy);
    for (int i = 1; i <= NUM_CH; i++)
      if (rdy[(last + i) % NUM_CH]) return (last + i) % NUM_CH;
    return -1;
  endfunction

  // Expected packet from the rules: header, reads from the next cycle, end pulse right after the last read
  function automatic pkt_t exp_pkt(int ch, int wc, int hdr, int delay);
    pkt_t p;
    p.ch = ch; p.wc = wc; p.hdr = hdr;
    if (wc == 0) begin
      p.first_rd = 0; p.rd_len = 0; p.kind = 1; p.endc = hdr + 1;
    end else begin
      p.first_rd = hdr + 1;
      if (delay < 1 || delay > TIMEOUT_CYC) begin p.rd_len = TIMEOUT_CYC; p.kind = 2; end
      else begin p.rd_len = delay; p.kind = 1; end
      p.endc = hdr + 1 + p.rd_len;
    end
    return p;
  endfunction

  function automatic string fmt(pkt_t p);
    return $sformatf("ch=%0d wc=%0d hdr=%0d rd0=%0d len=%0d kind=%0d end=%0d",
                     p.ch, p.wc, p.hdr, p.first_rd, p.rd_len, p.kind, p.endc);
  endfunction

  task automatic test_reset();
    reset_tx_n_i = 1'b0; enable_i = 1'b1; tx_busy_i = 1'b0; ch_ready_i = '1;
    for (int k = 0; k < NUM_CH; k++) begin wcs[k] = 16'd5; lw_delay[k] = 4; end
    apply_wc();
    repeat (3) tick();
    checks++; if (rd_en_o !== '0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en_o); end
    checks++; if (wdcnt_o !== 16'd0) begin errors++; $display("FAIL reset_wdcnt got %0d want 0", wdcnt_o); end
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id_o); end
    checks++; if ({hdr_start_o, pkt_done_o, timeout_o} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {hdr_start_o, pkt_done_o, timeout_o}); end
    enable_i = 1'b0; ch_ready_i = '0;
    reset_tx_n_i = 1'b1; m_last = NUM_CH - 1;
    repeat (2) tick();
    checks++; if (hdr_start_o !== 1'b0 || pkts.size() != 0) begin
      errors++; $display("FAIL reset_idle got hdr=%b pkts=%0d want 0/0", hdr_start_o, pkts.size()); end
  endtask

  task automatic test_single();
    int t0; bit ok; int ec; pkt_t e;
    ch_ready_i = 4'b0001; wcs[0] = 16'd16; apply_wc();
    lw_delay[0] = $urandom_range(2, 10);
    run_pkts(2, 300, t0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_count got %0d want 2", pkts.size()); end
    for (int i = 0; i < pkts.size(); i++) begin
      ec = rr_pick(m_last, ch_ready_i); m_last = ec;
      e = exp_pkt(ec, 16, (i == 0) ? t0 + 1 : e.endc + GAP_CYCLES + 1, lw_delay[0]);
      checks++; if (pkts[i] !== e) begin errors++; $display("FAIL single pkt%0d got %s want %s", i, fmt(pkts[i]), fmt(e)); end
    end
  endtask

  task automatic test_rr();
    int t0; bit ok; int ec; pkt_t e; int order[5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    ch_ready_i = 4'b1111;
    for (int k = 0; k < NUM_CH; k++) begin wcs[k] = 16'($urandom_range(1, 500)); lw_delay[k] = 4; end
    apply_wc();
    run_pkts(5, 400, t0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_count got %0d want 5", pkts.size()); end
    for (int i = 0; i < pkts.size(); i++) begin
      ec = rr_pick(m_last, ch_ready_i); m_last = ec;
      e = exp_pkt(ec, int'(wcs[ec]), (i == 0) ? t0 + 1 : e.endc + GAP_CYCLES + 1, 4);
      checks++; if (pkts[i] !== e) begin errors++; $display("FAIL rr pkt%0d got %s want %s", i, fmt(pkts[i]), fmt(e)); end
      checks++; if (pkts[i].ch != order[i]) begin errors++; $display("FAIL rr_order pkt%0d got ch%0d want ch%0d", i, pkts[i].ch, order[i]); end
    end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL rr_onehot got %0d bad rd_en cycles want 0", bad_rd); end
  endtask

  task automatic test_zero_wc();
    int t0; bit ok; int ec; pkt_t e;
    ch_ready_i = 4'b0100; wcs[2] = 16'd0; apply_wc();
    run_pkts(2, 200, t0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_wc_count got %0d want 2", pkts.size()); end
    for (int i = 0; i < pkts.size(); i++) begin
      ec = rr_pick(m_last, ch_ready_i); m_last = ec;
      e = exp_pkt(ec, 0, (i == 0) ? t0 + 1 : e.endc + GAP_CYCLES + 1, 1);
      checks++; if (pkts[i] !== e) begin errors++; $display("FAIL zero_wc pkt%0d got %s want %s", i, fmt(pkts[i]), fmt(e)); end
    end
  endtask

  task automatic test_timeout();
    int t0; bit ok; int ec; pkt_t e;
    ch_ready_i = 4'b0010; wcs[1] = 16'($urandom_range(1, 60000)); apply_wc();
    lw_delay[1] = -1;
    run_pkts(2, 2 * TIMEOUT_CYC + 100, t0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_count got %0d want 2", pkts.size()); end
    for (int i = 0; i < pkts.size(); i++) begin
      ec = rr_pick(m_last, ch_ready_i); m_last = ec;
      e = exp_pkt(ec, int'(wcs[1]), (i == 0) ? t0 + 1 : e.endc + GAP_CYCLES + 1, -1);
      checks++; if (pkts[i] !== e) begin errors++; $display("FAIL timeout pkt%0d got %s want %s", i, fmt(pkts[i]), fmt(e)); end
    end
    // lastwd on the very cycle the counter expires
    lw_delay[1] = TIMEOUT_CYC;
    run_pkts(1, TIMEOUT_CYC + 100, t0, ok);
    ec = rr_pick(m_last, ch_ready_i); m_last = ec;
    e = exp_pkt(ec, int'(wcs[1]), t0 + 1, TIMEOUT_CYC);
    checks++; if (!ok || pkts[0] !== e) begin
      errors++; $display("FAIL timeout_tie got %s want %s", ok ? fmt(pkts[0]) : "none", fmt(e)); end
  endtask

  task automatic test_busy_enable();
    int t0; int ec; pkt_t e; logic [15:0] orig;
    ch_ready_i = 4'b0011; wcs[0] = 16'd100; wcs[1] = 16'd200; apply_wc();
    lw_delay[0] = 30; lw_delay[1] = 30;
    pkts.delete(); tx_busy_i = 1'b1; enable_i = 1'b1;
    repeat (20) tick();
    checks++; if (open || pkts.size() != 0) begin
      errors++; $display("FAIL busy_hold got open=%0d pkts=%0d want 0/0", open, pkts.size()); end
    tx_busy_i = 1'b0; t0 = ncyc;
    ec = rr_pick(m_last, ch_ready_i); m_last = ec;
    for (int c = 0; c < 10 && !open; c++) tick();
    checks++; if (!open || cur.hdr != t0 + 1 || cur.ch != ec) begin
      errors++; $display("FAIL busy_release got open=%0d hdr=%0d ch=%0d want 1/%0d/%0d", open, cur.hdr, cur.ch, t0 + 1, ec); end
    for (int c = 0; c < 50 && cur.rd_len < 5; c++) tick();
    orig = wcs[ec];
    enable_i = 1'b0; tx_busy_i = 1'b1; ch_ready_i = '1;
    ch_wc_i[16*ec +: 16] = orig + 16'd1;
    for (int c = 0; c < 200 && pkts.size() < 1; c++) tick();
    checks++; if (wdcnt_o !== orig) begin errors++; $display("FAIL wc_held got %0d want %0d", wdcnt_o, orig); end
    repeat (40) tick();
    checks++; if (pkts.size() != 1 || open) begin
      errors++; $display("FAIL enable_drop got pkts=%0d open=%0d want 1/0", pkts.size(), open); end
    e = exp_pkt(ec, int'(orig), t0 + 1, 30);
    checks++; if (pkts.size() == 0 || pkts[0] !== e) begin
      errors++; $display("FAIL enable_drop_pkt got %s want %s", pkts.size() ? fmt(pkts[0]) : "none", fmt(e)); end
    tx_busy_i = 1'b0; apply_wc();
  endtask

  task automatic test_random();
    int t0; bit ok; int ec; int n; pkt_t e;
    for (int r = 0; r < 6; r++) begin
      ch_ready_i = NUM_CH'($urandom_range(1, 15));
      for (int k = 0; k < NUM_CH; k++) begin
        wcs[k] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
        lw_delay[k] = $urandom_range(1, 12);
      end
      apply_wc();
      n = $urandom_range(3, 6);
      run_pkts(n, 600, t0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_count round%0d got %0d want %0d", r, pkts.size(), n); end
      for (int i = 0; i < pkts.size(); i++) begin
        ec = rr_pick(m_last, ch_ready_i); m_last = ec;
        e = exp_pkt(ec, int'(wcs[ec]), (i == 0) ? t0 + 1 : e.endc + GAP_CYCLES + 1, lw_delay[ec]);
        checks++; if (pkts[i] !== e) begin
          errors++; $display("FAIL rand r%0d pkt%0d got %s want %s", r, i, fmt(pkts[i]), fmt(e)); end
      end
    end
    checks++; if (bad_rd != 0 || bad_pulse != 0) begin
      errors++; $display("FAIL protocol got bad_rd=%0d bad_pulse=%0d want 0/0", bad_rd, bad_pulse); end
  endtask

  task automatic test_reset_mid();
    int t0; bit ok; pkt_t e;
    ch_ready_i = 4'b0100; wcs[2] = 16'd100; apply_wc();
    lw_delay[2] = -1;
    pkts.delete(); enable_i = 1'b1;
    for (int c = 0; c < 50 && !(open && cur.rd_len >= 10); c++) tick();
    checks++; if (rd_en_o !== 4'b0100) begin errors++; $display("FAIL pre_reset_rd_en got %b want 0100", rd_en_o); end
    reset_tx_n_i = 1'b0;
    #1;
    checks++; if (rd_en_o !== '0) begin errors++; $display("FAIL async_rd_en got %b want 0", rd_en_o); end
    checks++; if (grant_id_o !== 2'd0 || wdcnt_o !== 16'd0 || {hdr_start_o, pkt_done_o, timeout_o} !== 3'b000) begin
      errors++; $display("FAIL async_outs got grant=%0d wc=%0d pulses=%b want 0/0/000",
                         grant_id_o, wdcnt_o, {hdr_start_o, pkt_done_o, timeout_o}); end
    enable_i = 1'b0;
    repeat (3) tick();
    ch_ready_i = 4'b1111; reset_tx_n_i = 1'b1; m_last = NUM_CH - 1;
    for (int k = 0; k < NUM_CH; k++) lw_delay[k] = 3;
    repeat (2) tick();
    checks++; if (pkts.size() != 0 || open) begin
      errors++; $display("FAIL reset_abort got pkts=%0d open=%0d want 0/0", pkts.size(), open); end
    run_pkts(1, 200, t0, ok);
    e = exp_pkt(rr_pick(m_last, ch_ready_i), int'(wcs[0]), t0 + 1, 3);
    checks++; if (!ok || pkts[0] !== e || pkts[0].ch != 0) begin
      errors++; $display("FAIL reset_priority got %s want %s", ok ? fmt(pkts[0]) : "none", fmt(e)); end
  endtask

  initial begin
    reset_tx_n_i = 1'b0; enable_i = 1'b0; tx_busy_i = 1'b0;
    ch_ready_i = '0; ch_wc_i = '0; m_last = NUM_CH - 1;
    for (int k = 0; k < NUM_CH; k++) begin lw_delay[k] = 4; wcs[k] = '0; end
    test_reset();
    test_single();
    test_rr();
    test_zero_wc();
    test_timeout();
    test_busy_enable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
